// File: rtl/sm83_mem_responder.sv
// rtl/sm83_mem_responder.sv - CPU memory-bus responder for boot ROM, WRAM, HRAM and the boot register
// Optional echo-RAM mirror of WRAM at 0xE000-0xFDFF is enabled by defining SM83_ECHO_RAM_EN.
module sm83_mem_responder #(
  parameter int         HRAM_BYTES    = 127,
  parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  input  logic        mem_cs,
  input  logic        mem_oe,
  input  logic        mem_wr,
  output logic        mem_ready,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [7:0]  rom_dout,
  output logic [12:0] wram_addr,
  output logic        wram_en,
  output logic        wram_we,
  output logic [7:0]  wram_din,
  input  logic [7:0]  wram_dout,
  output logic        boot_en
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_DONE} state_t;
  typedef enum logic [2:0] {R_NONE, R_ROM, R_WRAM, R_HRAM, R_BOOT} region_t;

  localparam int          HW       = $clog2(HRAM_BYTES);
  localparam logic [31:0] HRAM_END = 32'hFF80 + 32'(HRAM_BYTES);

  state_t      state_q, state_d;
  region_t     region_q, region_in;
  logic [12:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic        boot_en_q;
  logic        latch;
  logic [7:0]  hram_q [HRAM_BYTES];

  always_comb begin
    region_in = R_NONE;
    if (addr_bus[15:8] == 8'h00 && boot_en_q)
      region_in = R_ROM;
    else if (addr_bus[15:13] == 3'b110)
      region_in = R_WRAM;
`ifdef SM83_ECHO_RAM_EN
    else if (addr_bus >= 16'hE000 && addr_bus <= 16'hFDFF)
      region_in = R_WRAM;
`endif
    else if (addr_bus == 16'hFF50)
      region_in = R_BOOT;
    else if ({16'd0, addr_bus} >= 32'hFF80 && {16'd0, addr_bus} < HRAM_END)
      region_in = R_HRAM;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_cs && mem_wr)      state_d = S_WR;
        else if (mem_cs && mem_oe) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_DONE;
      S_WR:      state_d = S_DONE;
      S_DONE:    if (!mem_cs) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_en      = (state_q == S_RD_ADDR) && (region_q == R_ROM);
    wram_en     = (state_q == S_RD_ADDR || state_q == S_WR) && (region_q == R_WRAM);
    wram_we     = (state_q == S_WR) && (region_q == R_WRAM);
    rdata_oe    = (state_q == S_DONE);
    latch       = (state_q == S_IDLE) && (state_d != S_IDLE);
    mem_ready_d = (state_q != S_DONE) && (state_d == S_DONE);
  end

  // Read mux is sampled in RD_DATA, once BRAM outputs are valid.
  always_comb begin
    case (region_q)
      R_ROM:   rdata_d = rom_dout;
      R_WRAM:  rdata_d = wram_dout;
      R_HRAM:  rdata_d = hram_q[addr_q[HW-1:0]];
      R_BOOT:  rdata_d = {7'b1111111, ~boot_en_q};
      default: rdata_d = UNMAPPED_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      region_q    <= R_NONE;
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      boot_en_q   <= 1'b1;
    end else begin
      mem_ready_q <= mem_ready_d;
      if (latch) begin
        addr_q   <= addr_bus[12:0];
        wdata_q  <= wdata;
        region_q <= region_in;
      end
      if (state_q == S_RD_DATA)
        rdata_q <= rdata_d;
      if (state_q == S_WR && region_q == R_BOOT && wdata_q != 8'h00)
        boot_en_q <= 1'b0;
    end
  end

  // HRAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_WR && region_q == R_HRAM)
      hram_q[addr_q[HW-1:0]] <= wdata_q;
  end

  assign rdata     = rdata_q;
  assign mem_ready = mem_ready_q;
  assign rom_addr  = addr_q[7:0];
  assign wram_addr = addr_q;
  assign wram_din  = wdata_q;
  assign boot_en   = boot_en_q;

endmodule

// File: tb/tb_sm83_mem_responder.sv
// tb/tb_sm83_mem_responder.sv - directed self-checking bench for sm83_mem_responder
// Boot ROM and WRAM are modelled as synchronous single-port BRAMs.
module tb_sm83_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        mem_cs, mem_oe, mem_wr;
  logic        mem_ready;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [7:0]  rom_dout;
  logic [12:0] wram_addr;
  logic        wram_en, wram_we;
  logic [7:0]  wram_din;
  logic [7:0]  wram_dout;
  logic        boot_en;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rom_mem  [256];
  logic [7:0]  wram_mem [8192];
  int          we_cnt = 0;
  int          we0;
  logic [12:0] last_we_addr;
  logic [7:0]  last_we_din;
  logic [7:0]  x_data;
  int          x_lat, x_oe_err, x_extra, idle_err;

  always #5 clk = ~clk;

  sm83_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr_bus  (addr_bus),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_oe  (rdata_oe),
    .mem_cs    (mem_cs),
    .mem_oe    (mem_oe),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_dout  (rom_dout),
    .wram_addr (wram_addr),
    .wram_en   (wram_en),
    .wram_we   (wram_we),
    .wram_din  (wram_din),
    .wram_dout (wram_dout),
    .boot_en   (boot_en)
  );

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_mem[rom_addr];
    if (wram_en) begin
      if (wram_we) wram_mem[wram_addr] <= wram_din;
      else         wram_dout <= wram_mem[wram_addr];
    end
    if (wram_we) we_cnt <= we_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One handshake; addr_bus is scrambled after the request edge to prove latching.
  task automatic xfer(input logic [15:0] a, input logic [7:0] d, input logic oe,
                      input logic wr, input int hold);
    addr_bus = a; wdata = d; mem_cs = 1'b1; mem_oe = oe; mem_wr = wr;
    x_lat = 0; x_oe_err = 0; x_extra = 0;
    while (mem_ready !== 1'b1 && x_lat < 20) begin
      tick;
      x_lat++;
      addr_bus = ~a; wdata = ~d;
      if (wram_we === 1'b1) begin
        last_we_addr = wram_addr;
        last_we_din  = wram_din;
      end
      if (mem_ready !== 1'b1 && rdata_oe !== 1'b0) x_oe_err++;
    end
    if (x_lat >= 20) x_lat = 99;
    x_data = rdata;
    if (rdata_oe !== 1'b1) x_oe_err++;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (mem_ready !== 1'b0) x_extra++;
      if (rom_en !== 1'b0 || wram_en !== 1'b0) x_extra++;
      if (rdata_oe !== 1'b1) x_oe_err++;
    end
    mem_cs = 1'b0; mem_oe = 1'b0; mem_wr = 1'b0;
    tick;
    if (rdata_oe !== 1'b0 || mem_ready !== 1'b0) x_oe_err++;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    xfer(a, 8'h00, 1'b1, 1'b0, 0);
    chk({tag, "_lat"}, 32'(x_lat), 32'd3);
    chk({tag, "_data"}, 32'(x_data), 32'(exp));
    chk({tag, "_oe"}, 32'(x_oe_err), 32'd0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int exp_we, input string tag);
    we0 = we_cnt;
    xfer(a, d, 1'b0, 1'b1, 0);
    chk({tag, "_lat"}, 32'(x_lat), 32'd2);
    chk({tag, "_we"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  initial begin
    for (int i = 0; i < 256; i++)  rom_mem[i] = 8'h00;
    for (int i = 0; i < 8192; i++) wram_mem[i] = 8'h00;
    rom_mem[0] = 8'h31;
    rom_dout = 8'h00; wram_dout = 8'h00;
    rst = 1'b1; addr_bus = 16'h0000; wdata = 8'h00;
    mem_cs = 1'b0; mem_oe = 1'b0; mem_wr = 1'b0;
    repeat (3) tick;
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_oe", 32'(rdata_oe), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_strobes", 32'({rom_en, wram_en, wram_we}), 32'd0);
    chk("rst_addrs", 32'({rom_addr, wram_addr, wram_din}), 32'd0);
    chk("rst_boot_en", 32'(boot_en), 32'd1);
    rst = 1'b0;
    tick;

    rd(16'h0000, 8'h31, "rom0");
    rd(16'hFF50, 8'hFE, "bootreg_on");
    wr(16'hFF50, 8'h00, 0, "boot_wr0");
    chk("boot_zero_keeps", 32'(boot_en), 32'd1);

    wr(16'hC123, 8'hA5, 1, "wram_wr");
    chk("wram_we_addr", 32'(last_we_addr), 32'h0123);
    chk("wram_we_din", 32'(last_we_din), 32'hA5);
    rd(16'hC123, 8'hA5, "wram_rd");

    wr(16'h0000, 8'h12, 0, "rom_wr");
    rd(16'h0000, 8'h31, "rom_after_wr");

    wr(16'hFF50, 8'h01, 0, "boot_off");
    chk("boot_cleared", 32'(boot_en), 32'd0);
    rd(16'h0000, 8'hFF, "rom_unmapped");
    rd(16'hFF50, 8'hFF, "bootreg_off");

    wr(16'hFF80, 8'h5A, 0, "hram_lo_wr");
    rd(16'hFF80, 8'h5A, "hram_lo_rd");
    wr(16'hFFFE, 8'h3C, 0, "hram_hi_wr");
    rd(16'hFFFE, 8'h3C, "hram_hi_rd");
    rd(16'hFF80, 8'h5A, "hram_lo_kept");
    rd(16'hFFFF, 8'hFF, "ffff_unmapped");
    rd(16'h8000, 8'hFF, "vram_unmapped");
    wr(16'h8000, 8'h77, 0, "vram_wr");

    xfer(16'hC123, 8'h00, 1'b1, 1'b0, 5);
    chk("hold_lat", 32'(x_lat), 32'd3);
    chk("hold_data", 32'(x_data), 32'hA5);
    chk("hold_extra", 32'(x_extra), 32'd0);
    chk("hold_oe", 32'(x_oe_err), 32'd0);

    idle_err = 0;
    addr_bus = 16'hC123; mem_cs = 1'b1; mem_oe = 1'b0; mem_wr = 1'b0;
    repeat (4) begin
      tick;
      if (mem_ready !== 1'b0 || rom_en !== 1'b0 || wram_en !== 1'b0 || rdata_oe !== 1'b0)
        idle_err++;
    end
    mem_cs = 1'b0;
    tick;
    chk("cs_no_qual", 32'(idle_err), 32'd0);

    we0 = we_cnt;
    xfer(16'hC010, 8'h77, 1'b1, 1'b1, 0);
    chk("both_lat", 32'(x_lat), 32'd2);
    chk("both_we", 32'(we_cnt - we0), 32'd1);
    rd(16'hC010, 8'h77, "both_rd");

    addr_bus = 16'hC010; mem_cs = 1'b1; mem_oe = 1'b1; mem_wr = 1'b0;
    tick;
    tick;
    rst = 1'b1; mem_cs = 1'b0; mem_oe = 1'b0;
    tick;
    chk("abort_ready", 32'(mem_ready), 32'd0);
    chk("abort_oe", 32'(rdata_oe), 32'd0);
    chk("abort_boot_en", 32'(boot_en), 32'd1);
    chk("abort_strobes", 32'({rom_en, wram_en, wram_we}), 32'd0);
    rst = 1'b0;
    tick;
    rd(16'h0000, 8'h31, "rom_after_rst");
    rd(16'hC010, 8'h77, "wram_after_rst");
    rd(16'hFF80, 8'h5A, "hram_after_rst");

`ifdef SM83_ECHO_RAM_EN
    wr(16'hE010, 8'h99, 1, "echo_wr");
    rd(16'hC010, 8'h99, "echo_mirror");
    rd(16'hFDFF, 8'h00, "echo_top");
`else
    wr(16'hE010, 8'h99, 0, "echo_wr");
    rd(16'hE010, 8'hFF, "echo_unmapped");
    rd(16'hC010, 8'h77, "echo_no_mirror");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
